// File: rtl/ftoi_pipe.sv
// Two-stage binary32 -> signed/unsigned integer converter with valid/ready flow control.
// Stage 1 aligns the significand to an integer part plus round/sticky bits; stage 2 rounds, range-checks and negates.
module ftoi_pipe #(
  parameter int OUT_W = 32,
  parameter int BIAS  = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      x,
  input  logic [2:0]       rm,
  input  logic             uns,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] y,
  output logic             nv,
  output logic             nx,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int IW   = OUT_W + 1;
  localparam int MAXL = OUT_W - 23;
  localparam int PADW = 26;
  localparam int EXTW = 24 + PADW;

  localparam logic signed [9:0] EOFF   = 10'(BIAS + 23);
  localparam logic signed [9:0] MAXL_S = 10'(MAXL);
  localparam logic signed [9:0] RMAX_S = 10'(PADW);

  localparam logic [IW-1:0] SPOS_MAX = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [IW-1:0] SNEG_MAX = {2'b01, {(OUT_W-1){1'b0}}};

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Rounding increment; RTZ and the reserved encodings never round away from zero.
  function automatic logic rnd_inc(input logic [2:0] mode, input logic neg,
                                   input logic lsb, input logic rb, input logic sb);
    logic inc;
    inc = 1'b0;
    case (mode)
      RM_RNE:  inc = rb & (sb | lsb);
      RM_RDN:  inc = neg & (rb | sb);
      RM_RUP:  inc = ~neg & (rb | sb);
      RM_RMM:  inc = rb;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  function automatic logic [OUT_W-1:0] sat_val(input logic u, input logic neg);
    logic [OUT_W-1:0] v;
    if (u)
      v = neg ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
    else
      v = neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return v;
  endfunction

  // Unsigned negatives are representable only when they round to zero.
  function automatic logic fits(input logic u, input logic neg, input logic [IW-1:0] mag);
    logic ok;
    if (u)
      ok = neg ? (mag == {IW{1'b0}}) : !mag[IW-1];
    else
      ok = neg ? (mag <= SNEG_MAX) : (mag <= SPOS_MAX);
    return ok;
  endfunction

  logic                 vld_p1_q, vld_p1_d;
  logic                 vld_p2_q, vld_p2_d;
  logic                 adv_p2, ld_p1, ld_p2;

  logic                 sign_p0, nan_p0;
  logic [7:0]           exp_p0;
  logic [22:0]          man_p0;
  logic [23:0]          sig_p0;
  logic signed [9:0]    exp_unb_p0, neg_p0;
  logic [5:0]           lsh_p0;
  logic [4:0]           rsh_p0;
  logic [EXTW-1:0]      ext_p0;

  logic [IW-1:0]        int_p1_d, int_p1_q;
  logic                 rb_p1_d, rb_p1_q;
  logic                 sb_p1_d, sb_p1_q;
  logic                 ovf_p1_d, ovf_p1_q;
  logic                 sign_p1_q, nan_p1_q, uns_p1_q;
  logic [2:0]           rm_p1_q;

  logic                 inc_p1;
  logic [IW-1:0]        mag_p1;
  logic [OUT_W-1:0]     y_p2_d, y_p2_q;
  logic                 nv_p2_d, nv_p2_q;
  logic                 nx_p2_d, nx_p2_q;

  // Handshake: a stage advances when the stage after it is empty or draining.
  always_comb begin
    adv_p2   = !vld_p2_q || out_ready;
    in_ready = !vld_p1_q || adv_p2;
    ld_p1    = in_valid && in_ready;
    ld_p2    = vld_p1_q && adv_p2;
    vld_p1_d = ld_p1 || (vld_p1_q && !adv_p2);
    vld_p2_d = ld_p2 || (vld_p2_q && !out_ready);
  end

  // ---- stage 0 -> 1: decode and align ----
  always_comb begin
    sign_p0    = x[31];
    exp_p0     = x[30:23];
    man_p0     = x[22:0];
    sig_p0     = {|exp_p0, man_p0};
    nan_p0     = (&exp_p0) && (|man_p0);
    exp_unb_p0 = $signed({2'b00, exp_p0}) - EOFF;
    neg_p0     = -exp_unb_p0;
    lsh_p0     = exp_unb_p0[5:0];
    rsh_p0     = neg_p0[4:0];
    ext_p0     = {sig_p0, {PADW{1'b0}}} >> rsh_p0;

    int_p1_d = {IW{1'b0}};
    rb_p1_d  = 1'b0;
    sb_p1_d  = 1'b0;
    ovf_p1_d = 1'b0;
    if (exp_unb_p0 > MAXL_S) begin
      ovf_p1_d = 1'b1;
    end else if (!exp_unb_p0[9]) begin
      int_p1_d = {{MAXL{1'b0}}, sig_p0} << lsh_p0;
    end else if (neg_p0 > RMAX_S) begin
      sb_p1_d = |sig_p0;
    end else begin
      int_p1_d = {{MAXL{1'b0}}, ext_p0[EXTW-1:PADW]};
      rb_p1_d  = ext_p0[PADW-1];
      sb_p1_d  = |ext_p0[PADW-2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (ld_p1) begin
      int_p1_q  <= int_p1_d;
      rb_p1_q   <= rb_p1_d;
      sb_p1_q   <= sb_p1_d;
      ovf_p1_q  <= ovf_p1_d;
      sign_p1_q <= sign_p0;
      nan_p1_q  <= nan_p0;
      uns_p1_q  <= uns;
      rm_p1_q   <= rm;
    end
  end

  // ---- stage 1 -> 2: round, range check, negate ----
  always_comb begin
    inc_p1  = rnd_inc(rm_p1_q, sign_p1_q, int_p1_q[0], rb_p1_q, sb_p1_q);
    mag_p1  = int_p1_q + {{OUT_W{1'b0}}, inc_p1};
    y_p2_d  = {OUT_W{1'b0}};
    nv_p2_d = 1'b0;
    nx_p2_d = 1'b0;
    if (nan_p1_q) begin
      y_p2_d  = sat_val(uns_p1_q, 1'b0);
      nv_p2_d = 1'b1;
    end else if (ovf_p1_q || !fits(uns_p1_q, sign_p1_q, mag_p1)) begin
      y_p2_d  = sat_val(uns_p1_q, sign_p1_q);
      nv_p2_d = 1'b1;
    end else begin
      y_p2_d  = sign_p1_q ? -mag_p1[OUT_W-1:0] : mag_p1[OUT_W-1:0];
      nx_p2_d = rb_p1_q | sb_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      y_p2_q   <= {OUT_W{1'b0}};
      nv_p2_q  <= 1'b0;
      nx_p2_q  <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      if (ld_p2) begin
        y_p2_q  <= y_p2_d;
        nv_p2_q <= nv_p2_d;
        nx_p2_q <= nx_p2_d;
      end
    end
  end

  assign y         = y_p2_q;
  assign nv        = nv_p2_q;
  assign nx        = nx_p2_q;
  assign out_valid = vld_p2_q;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: table-driven vectors through an in-order scoreboard, plus
// latency, stall, reset and 64-bit corner sequences.
module tb_ftoi_pipe;

  typedef struct {
    logic [31:0] x;
    logic [2:0]  rm;
    logic        uns;
    logic [31:0] y;
    logic        nv;
    logic        nx;
  } vec_t;

  typedef struct packed {
    logic [31:0] y;
    logic        nv;
    logic        nx;
  } exp_t;

  logic        clk, rst;
  logic [31:0] x;
  logic [2:0]  rm;
  logic        uns, in_valid, in_ready, out_valid, out_ready, nv, nx;
  logic [31:0] y;

  logic [31:0] x64;
  logic [2:0]  rm64;
  logic        uns64, iv64, ir64, ov64, or64, nv64, nx64;
  logic [63:0] y64;

  exp_t sb[$];
  exp_t cur_exp;
  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;
  int   cyc = 0;
  int   or_mode = 0;

  ftoi_pipe #(.OUT_W(32), .BIAS(127)) dut (
    .clk(clk), .rst(rst), .x(x), .rm(rm), .uns(uns),
    .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .nv(nv), .nx(nx),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  ftoi_pipe #(.OUT_W(64), .BIAS(127)) dut64 (
    .clk(clk), .rst(rst), .x(x64), .rm(rm64), .uns(uns64),
    .in_valid(iv64), .in_ready(ir64),
    .y(y64), .nv(nv64), .nx(nx64),
    .out_valid(ov64), .out_ready(or64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  // out_ready: 0 = always 1, 1 = repeating 1,0,0,1, 2 = held low
  initial begin
    logic [3:0] pat;
    logic [1:0] pidx;
    pat = 4'b1001;
    pidx = 2'd0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = pat[pidx];
          pidx = pidx + 2'd1;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: samples on the falling edge, between driver updates.
  initial begin
    logic        stall_prev;
    logic [31:0] hy;
    logic        hnv, hnx, hov;
    exp_t        e;
    stall_prev = 1'b0;
    hy = '0; hnv = 1'b0; hnx = 1'b0; hov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          chk("stall_hold", 64'({y, nv, nx, out_valid}), 64'({hy, hnv, hnx, hov}));
        if (out_valid && out_ready) begin
          n_out++;
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL spurious_out: got y=%0h with no pending operand, required none", y);
          end else begin
            e = sb.pop_front();
            chk("y", 64'(y), 64'(e.y));
            chk("nv_nx", 64'({nv, nx}), 64'({e.nv, e.nx}));
          end
        end
        if (in_valid && in_ready) sb.push_back(cur_exp);
        stall_prev = out_valid && !out_ready;
        hy = y; hnv = nv; hnx = nx; hov = out_valid;
      end
    end
  end

  task automatic send(input logic [31:0] xv, input logic [2:0] rmv, input logic uv,
                      input logic [31:0] ye, input logic nve, input logic nxe);
    int   w;
    logic acc;
    x = xv; rm = rmv; uns = uv;
    cur_exp = {ye, nve, nxe};
    in_valid = 1'b1;
    w = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      w++;
    end while (!acc && w < 50);
    if (!acc) begin
      n_chk++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 60) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  task automatic run64(input logic [31:0] xv, input logic [2:0] rmv, input logic uv,
                       input logic [63:0] ye, input logic nve, input logic nxe);
    int w;
    x64 = xv; rm64 = rmv; uns64 = uv; iv64 = 1'b1;
    @(posedge clk);
    #1;
    iv64 = 1'b0;
    w = 0;
    while (!ov64 && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("valid64", 64'(ov64), 64'd1);
    chk("y64", y64, ye);
    chk("nv_nx64", 64'({nv64, nx64}), 64'({nve, nxe}));
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [31:0] xv, input logic [2:0] rmv, input logic uv,
                     input logic [31:0] ye, input logic nve, input logic nxe);
    vec_t v;
    v.x = xv; v.rm = rmv; v.uns = uv; v.y = ye; v.nv = nve; v.nx = nxe;
    vecs.push_back(v);
  endtask

  initial begin
    int cnt, lat, t0, ovc;
    rst = 1'b1; in_valid = 1'b0; x = '0; rm = '0; uns = 1'b0; cur_exp = '0;
    x64 = '0; rm64 = '0; uns64 = 1'b0; iv64 = 1'b0; or64 = 1'b1;

    //            x             rm    uns   y             nv    nx
    add(32'h40200000, 3'd0, 1'b0, 32'h00000002, 1'b0, 1'b1);
    add(32'h40200000, 3'd4, 1'b0, 32'h00000003, 1'b0, 1'b1);
    add(32'h40200000, 3'd3, 1'b0, 32'h00000003, 1'b0, 1'b1);
    add(32'h40200000, 3'd1, 1'b0, 32'h00000002, 1'b0, 1'b1);
    add(32'h40600000, 3'd0, 1'b0, 32'h00000004, 1'b0, 1'b1);
    add(32'hC0200000, 3'd2, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1);
    add(32'hC0200000, 3'd0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1);
    add(32'hC0200000, 3'd4, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1);
    add(32'hC0200000, 3'd3, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1);
    add(32'hCF000000, 3'd1, 1'b0, 32'h80000000, 1'b0, 1'b0);
    add(32'hCF000001, 3'd1, 1'b0, 32'h80000000, 1'b1, 1'b0);
    add(32'h4F000000, 3'd1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    add(32'h4F000000, 3'd1, 1'b1, 32'h80000000, 1'b0, 1'b0);
    add(32'h4EFFFFFF, 3'd0, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0);
    add(32'h4F7FFFFF, 3'd1, 1'b1, 32'hFFFFFF00, 1'b0, 1'b0);
    add(32'h4F7FFFFF, 3'd1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    add(32'h4F800000, 3'd1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    add(32'h7FC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    add(32'hFFC00000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    add(32'h7F800000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    add(32'hFF800000, 3'd0, 1'b0, 32'h80000000, 1'b1, 1'b0);
    add(32'hBE99999A, 3'd1, 1'b1, 32'h00000000, 1'b0, 1'b1);
    add(32'hBE99999A, 3'd2, 1'b1, 32'h00000000, 1'b1, 1'b0);
    add(32'hBE99999A, 3'd2, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
    add(32'hBF800000, 3'd1, 1'b1, 32'h00000000, 1'b1, 1'b0);
    add(32'hBF800000, 3'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
    add(32'h00000001, 3'd3, 1'b1, 32'h00000001, 1'b0, 1'b1);
    add(32'h00000000, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b0);
    add(32'h80000000, 3'd3, 1'b0, 32'h00000000, 1'b0, 1'b0);
    add(32'h80000000, 3'd1, 1'b1, 32'h00000000, 1'b0, 1'b0);
    add(32'h3F000000, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b1);
    add(32'h3F000000, 3'd3, 1'b0, 32'h00000001, 1'b0, 1'b1);
    add(32'h3FC00000, 3'd0, 1'b0, 32'h00000002, 1'b0, 1'b1);
    add(32'h3FC00000, 3'd5, 1'b0, 32'h00000001, 1'b0, 1'b1);
    add(32'h3F800000, 3'd7, 1'b0, 32'h00000001, 1'b0, 1'b0);

    // Reset, with an operand presented in the last reset cycle.
    repeat (2) @(posedge clk);
    #1;
    x = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_nv_nx", 64'({nv, nx}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0; in_valid = 1'b0;
    ovc = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid) ovc++;
    end
    chk("rst_operand_dropped", 64'(ovc), 64'd0);

    // Latency: operand presented in cycle c appears in cycle c+2.
    x = 32'h40200000; rm = 3'd0; uns = 1'b0; cur_exp = {32'd2, 1'b0, 1'b1};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd2);
    drain("drain_latency");

    // Table, back to back at full rate.
    t0 = cyc;
    foreach (vecs[i]) send(vecs[i].x, vecs[i].rm, vecs[i].uns, vecs[i].y, vecs[i].nv, vecs[i].nx);
    chk("throughput", 64'(cyc - t0), 64'(vecs.size()));
    drain("drain_table");

    // Eight operands against a stalling consumer.
    or_mode = 1;
    cnt = n_out;
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] fv;
      case (i)
        1: fv = 32'h3F800000;
        2: fv = 32'h40000000;
        3: fv = 32'h40400000;
        4: fv = 32'h40800000;
        5: fv = 32'h40A00000;
        6: fv = 32'h40C00000;
        7: fv = 32'h40E00000;
        default: fv = 32'h41000000;
      endcase
      send(fv, 3'd0, 1'b0, 32'(i), 1'b0, 1'b0);
    end
    drain("drain_stall");
    chk("stall_count", 64'(n_out - cnt), 64'd8);
    or_mode = 0;

    // Reset with two operands in flight.
    or_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(32'h3F800000, 3'd0, 1'b0, 32'd1, 1'b0, 1'b0);
    send(32'h40000000, 3'd0, 1'b0, 32'd2, 1'b0, 1'b0);
    chk("inflight_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_y", 64'(y), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    or_mode = 0;
    ovc = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) ovc++;
    end
    chk("no_stale", 64'(ovc), 64'd0);
    cnt = n_out;
    send(32'h40400000, 3'd1, 1'b0, 32'd3, 1'b0, 1'b0);
    drain("drain_post_rst");
    chk("post_rst_count", 64'(n_out - cnt), 64'd1);

    // 64-bit result width.
    chk("ir64_idle", 64'(ir64), 64'd1);
    run64(32'h5F000000, 3'd1, 1'b0, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0);
    run64(32'h5F000000, 3'd1, 1'b1, 64'h8000000000000000, 1'b0, 1'b0);
    run64(32'hDF000000, 3'd1, 1'b0, 64'h8000000000000000, 1'b0, 1'b0);
    run64(32'h5F800000, 3'd1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0);
    run64(32'hC0200000, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFD, 1'b0, 1'b1);
    run64(32'h3FC00000, 3'd0, 1'b0, 64'h0000000000000002, 1'b0, 1'b1);

    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
